alu_op_decode_stage: RTL

//   ID->EX pipeline stage that produces the ALU's operand and control inputs. Decodes
//   one RV32I instruction and muxes rs1/rs2/PC/immediate into ScrA/ScrB. Registers

---
 rtl/alu_op_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode_stage
//  Description : ID->EX pipeline stage. Decodes one RV32I instruction, selects
//                the ALU operands (rs1/rs2/PC/immediate) into ScrA/ScrB and
//                registers them with ALUControl, ALUType and the execute-stage
//                sideband controls. One-entry valid/ready pipeline register,
//                latency 1, with flush on redirect.
//  Ports       : clk, rst (sync, active-high), flush
//                in_valid/in_ready, in_instr, in_pc, in_rs1_data, in_rs2_data
//                out_valid/out_ready, ScrA, ScrB, ALUControl, ALUType,
//                out_imm, out_rs2_data, out_rd, out_reg_write, out_mem_read,
//                out_mem_write, out_illegal
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ScrA,
    output logic [XLEN-1:0] ScrB,
    output logic [3:0]      ALUControl,
    output logic [1:0]      ALUType,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b0110;
    localparam logic [3:0] c_ALU_SRA  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1000;
    localparam logic [3:0] c_ALU_SLTU = 4'b1001;

    localparam logic [1:0] c_TYPE_RI = 2'b00;
    localparam logic [1:0] c_TYPE_S  = 2'b01;
    localparam logic [1:0] c_TYPE_B  = 2'b10;
    localparam logic [1:0] c_TYPE_J  = 2'b11;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_shamt;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    assign w_shamt  = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    // ALU operation implied by funct3 for the base (funct7=0) encodings
    logic [3:0] w_alu_f3;
    always_comb begin
        w_alu_f3 = c_ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_f3 = c_ALU_ADD;
            3'b001:  w_alu_f3 = c_ALU_SLL;
            3'b010:  w_alu_f3 = c_ALU_SLT;
            3'b011:  w_alu_f3 = c_ALU_SLTU;
            3'b100:  w_alu_f3 = c_ALU_XOR;
            3'b101:  w_alu_f3 = c_ALU_SRL;
            3'b110:  w_alu_f3 = c_ALU_OR;
            default: w_alu_f3 = c_ALU_AND;
        endcase
    end

    // ------------------------------------------------------------------------
    // Decode and operand selection
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [3:0]      w_ctl;
    logic [1:0]      w_type;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs2;
    logic [4:0]      w_rd;
    logic            w_rw;
    logic            w_mr;
    logic            w_mw;
    logic            w_ill;

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_ctl  = c_ALU_ADD;
        w_type = c_TYPE_RI;
        w_imm  = '0;
        w_rs2  = in_rs2_data;
        w_rd   = in_instr[11:7];
        w_rw   = 1'b0;
        w_mr   = 1'b0;
        w_mw   = 1'b0;
        w_ill  = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_a  = in_rs1_data;
                w_b  = in_rs2_data;
                w_rw = 1'b1;
                if (w_funct7 == c_F7_BASE)
                    w_ctl = w_alu_f3;
                else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000)
                    w_ctl = c_ALU_SUB;
                else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101)
                    w_ctl = c_ALU_SRA;
                else
                    w_ill = 1'b1;
            end
            c_OPC_OPIMM: begin
                w_a   = in_rs1_data;
                w_b   = w_imm_i;
                w_imm = w_imm_i;
                w_ctl = w_alu_f3;
                w_rw  = 1'b1;
                // Shifts reuse imm[11:5] as funct7; only shamt feeds the ALU
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_b = w_shamt;
                    if (w_funct3 == 3'b101 && w_funct7 == c_F7_ALT)
                        w_ctl = c_ALU_SRA;
                    else if (w_funct7 != c_F7_BASE)
                        w_ill = 1'b1;
                end
            end
            c_OPC_LOAD: begin
                w_a   = in_rs1_data;
                w_b   = w_imm_i;
                w_imm = w_imm_i;
                w_rw  = 1'b1;
                w_mr  = 1'b1;
            end
            c_OPC_STORE: begin
                w_a    = in_rs1_data;
                w_b    = w_imm_s;
                w_imm  = w_imm_s;
                w_type = c_TYPE_S;
                w_mw   = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_a    = in_rs1_data;
                w_b    = in_rs2_data;
                w_imm  = w_imm_b;
                w_type = c_TYPE_B;
                case (w_funct3)
                    3'b000:  w_ctl = 4'b0000;
                    3'b001:  w_ctl = 4'b0001;
                    3'b100:  w_ctl = 4'b0010;
                    3'b101:  w_ctl = 4'b0011;
                    3'b110:  w_ctl = 4'b0100;
                    3'b111:  w_ctl = 4'b0101;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OPC_LUI: begin
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_rw  = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_a   = in_pc;
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_rw  = 1'b1;
            end
            c_OPC_JAL: begin
                w_a    = in_pc;
                w_b    = w_imm_j;
                w_imm  = w_imm_j;
                w_type = c_TYPE_J;
                w_rw   = 1'b1;
            end
            c_OPC_JALR: begin
                w_a    = in_rs1_data;
                w_b    = w_imm_i;
                w_imm  = w_imm_i;
                w_type = c_TYPE_J;
                w_rw   = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase

        // Illegal encodings travel down the pipe as an inert ADD with no side effects
        if (w_ill) begin
            w_a    = '0;
            w_b    = '0;
            w_ctl  = c_ALU_ADD;
            w_type = c_TYPE_RI;
            w_imm  = '0;
            w_rs2  = '0;
            w_rd   = '0;
            w_rw   = 1'b0;
            w_mr   = 1'b0;
            w_mw   = 1'b0;
        end
        if (w_rd == 5'd0)
            w_rw = 1'b0;
    end

    // ------------------------------------------------------------------------
    // One-entry pipeline register
    // ------------------------------------------------------------------------
    logic w_load;

    assign in_ready = !out_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            ScrA          <= '0;
            ScrB          <= '0;
            ALUControl    <= '0;
            ALUType       <= '0;
            out_imm       <= '0;
            out_rs2_data  <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (w_load) begin
                ScrA          <= w_a;
                ScrB          <= w_b;
                ALUControl    <= w_ctl;
                ALUType       <= w_type;
                out_imm       <= w_imm;
                out_rs2_data  <= w_rs2;
                out_rd        <= w_rd;
                out_reg_write <= w_rw;
                out_mem_read  <= w_mr;
                out_mem_write <= w_mw;
                out_illegal   <= w_ill;
            end
        end
    end

endmodule
`default_nettype wire
